gpu_apb_cmd_master: RTL

// - APB write master driving the GPU command slave port (pAddr/pDataWrite/pSel/pEnable/pWrite).
// - Accepts {opcode, parameters} commands from the host side over valid/ready, buffers them in a FIFO.
// - Issues one two-phase APB write per command, back-to-back when possible; holds off while GPU reports busy.
// - Sits between the host/CPU command source and the gpu top-level APB inputs.

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/gpu_cmd_fifo.sv | 61 ++++++
 rtl/gpu_apb_cmd_master.sv | 114 +++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// GPU command master shared types.
// Command bundle, APB FSM states and word packing.
package gpu_pkg;

   localparam int OPCODE_W = 4;
   localparam int PARAMS_W = 25;
   localparam int DATA_W   = 32;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [PARAMS_W-1:0] params;
   } gpu_cmd_t;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_state_t;

   function automatic logic [DATA_W-1:0] pack_cmd(input gpu_cmd_t c);
      return {3'b000, c.params, c.opcode};
   endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO.
// Exposes head and the entry behind it for back-to-back issue.
module gpu_cmd_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          i_push,
   input  gpu_cmd_t      i_data,
   input  logic          i_pop,
   output gpu_cmd_t      o_head,
   output gpu_cmd_t      o_head_nxt,
   output logic          o_full,
   output logic          o_empty,
   output logic [LW-1:0] o_level
);

   gpu_cmd_t        r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_count;
   logic [AW-1:0]   w_rd_nxt;
   logic            w_push;
   logic            w_pop;

   assign o_full     = (r_count == LW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_level    = r_count;
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;
   assign w_rd_nxt   = r_rd_ptr + AW'(1);
   assign o_head     = r_mem[r_rd_ptr];
   assign o_head_nxt = r_mem[w_rd_nxt];

   // Storage array; writes only land in free slots so the head is never hit.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers and occupancy, cleared by reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_nxt;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/gpu_apb_cmd_master.sv
// APB write master for the GPU command port.
// Buffers host commands, issues one two-phase write each.
module gpu_apb_cmd_master
   import gpu_pkg::*;
#(
   parameter int          DEPTH         = 4,
   parameter logic [31:0] GPU_BASE_ADDR = 32'h0000_0000,
   localparam int         LW            = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                cmd_valid_i,
   input  logic [OPCODE_W-1:0] cmd_opcode_i,
   input  logic [PARAMS_W-1:0] cmd_params_i,
   output logic                cmd_ready_o,
   input  logic                gpu_busy_i,
   output logic [31:0]         pAddr_o,
   output logic [31:0]         pDataWrite_o,
   output logic                pSel_o,
   output logic                pEnable_o,
   output logic                pWrite_o,
   output logic [LW-1:0]       level_o,
   output logic                idle_o
);

   apb_state_t  r_state;
   apb_state_t  w_next;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   gpu_cmd_t    w_cmd;
   gpu_cmd_t    w_head;
   gpu_cmd_t    w_head_nxt;
   logic [31:0] w_data_d;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        r_sel;
   logic        r_en;
   logic        r_wr;

   assign w_cmd       = '{opcode: cmd_opcode_i, params: cmd_params_i};
   assign cmd_ready_o = !w_full;
   assign w_push      = cmd_valid_i && cmd_ready_o;

   gpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_push     (w_push),
      .i_data     (w_cmd),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_head_nxt (w_head_nxt),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (level_o)
   );

   // Transfer sequencing and next APB data word.
   always_comb begin
      w_next   = r_state;
      w_pop    = 1'b0;
      w_data_d = '0;
      unique case (r_state)
         APB_IDLE: begin
            if (!w_empty && !gpu_busy_i) begin
               w_next   = APB_SETUP;
               w_data_d = pack_cmd(w_head);
            end
         end
         APB_SETUP: begin
            w_next   = APB_ACCESS;
            w_data_d = r_data;
         end
         APB_ACCESS: begin
            w_pop = 1'b1;
            if (level_o > LW'(1) && !gpu_busy_i) begin
               w_next   = APB_SETUP;
               w_data_d = pack_cmd(w_head_nxt);
            end else begin
               w_next = APB_IDLE;
            end
         end
         default: w_next = APB_IDLE;
      endcase
   end

   // State and registered APB outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= APB_IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_sel   <= 1'b0;
         r_en    <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_data  <= w_data_d;
         r_sel   <= (w_next != APB_IDLE);
         r_wr    <= (w_next != APB_IDLE);
         r_en    <= (w_next == APB_ACCESS);
         r_addr  <= (w_next != APB_IDLE) ? GPU_BASE_ADDR : '0;
      end
   end

   assign pAddr_o      = r_addr;
   assign pDataWrite_o = r_data;
   assign pSel_o       = r_sel;
   assign pEnable_o    = r_en;
   assign pWrite_o     = r_wr;
   assign idle_o       = (level_o == '0) && (r_state == APB_IDLE);

endmodule
